// File: rtl/layer1_accum_writeback_if.sv
// Partial-sum input stream and pixel-result output stream of the layer-1 writeback block.
// Latency n/a; valid/ready on both streams, the slave stalls in_ready while its result is unaccepted.
interface layer1_accum_writeback_if #(
  parameter int WORDLENGTH = 16,
  parameter int ADDR_W     = 10
);
  logic                    in_valid;
  logic                    in_ready;
  logic [8*WORDLENGTH-1:0] in_ch;
  logic                    out_valid;
  logic                    out_ready;
  logic [8*WORDLENGTH-1:0] out_data;
  logic [ADDR_W-1:0]       out_addr;

  modport master (
    output in_valid, in_ch, out_ready,
    input  in_ready, out_valid, out_data, out_addr
  );

  modport slave (
    input  in_valid, in_ch, out_ready,
    output in_ready, out_valid, out_data, out_addr
  );
endinterface

// File: rtl/layer1_accum_writeback.sv
// Accumulates TAPS partial-sum beats per pixel, adds bias, optional ReLU, saturates to Q6.10.
// Latency 1 cycle after the final beat; input stalls while a result is held unaccepted.
module layer1_accum_writeback #(
  parameter int WORDLENGTH = 16,
  parameter int ACC_W      = 24,
  parameter int TAPS       = 9,
  parameter int PIXELS     = 900,
  parameter int ADDR_W     = 10,
  parameter bit RELU_EN    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [8*WORDLENGTH-1:0] bias,
  layer1_accum_writeback_if.slave bus,
  output logic                    busy,
  output logic                    layer_done
);
  localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [TAP_W-1:0]        TAP_LAST = TAP_W'(TAPS - 1);
  localparam logic [ADDR_W-1:0]       PIX_LAST = ADDR_W'(PIXELS - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'((1 << (WORDLENGTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO   = ~SAT_HI;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

  state_t                  state;
  logic [TAP_W-1:0]        tap_cnt;
  logic [ADDR_W-1:0]       pix_cnt;
  logic signed [ACC_W-1:0] acc      [8];
  logic signed [ACC_W-1:0] beat_ext [8];
  logic signed [ACC_W-1:0] sum      [8];
  logic [8*WORDLENGTH-1:0] res;
  logic                    out_valid;
  logic [8*WORDLENGTH-1:0] out_data;
  logic [ADDR_W-1:0]       out_addr;
  logic                    in_ready;
  logic                    accept;

  assign in_ready      = (state == ACC) && (!out_valid || bus.out_ready);
  assign accept        = bus.in_valid && in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_addr  = out_addr;
  assign busy          = (state != IDLE);

  // Channel k maps to the k-th 16-bit lane counted from the MSB end (ch1 on top).
  always_comb begin
    res = '0;
    for (int k = 0; k < 8; k++) begin
      beat_ext[k] = ACC_W'($signed(bus.in_ch[(7-k)*WORDLENGTH +: WORDLENGTH]));
      sum[k] = acc[k] + beat_ext[k] + ACC_W'($signed(bias[(7-k)*WORDLENGTH +: WORDLENGTH]));
      if (RELU_EN && (sum[k] < 0)) sum[k] = '0;
      if (sum[k] > SAT_HI)      res[(7-k)*WORDLENGTH +: WORDLENGTH] = SAT_HI[WORDLENGTH-1:0];
      else if (sum[k] < SAT_LO) res[(7-k)*WORDLENGTH +: WORDLENGTH] = SAT_LO[WORDLENGTH-1:0];
      else                      res[(7-k)*WORDLENGTH +: WORDLENGTH] = sum[k][WORDLENGTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tap_cnt    <= '0;
      pix_cnt    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_addr   <= '0;
      layer_done <= 1'b0;
      for (int k = 0; k < 8; k++) acc[k] <= '0;
    end else begin
      layer_done <= 1'b0;
      if (out_valid && bus.out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ACC;
            tap_cnt <= '0;
            pix_cnt <= '0;
          end
        end
        ACC: begin
          if (accept) begin
            if (tap_cnt == TAP_LAST) begin
              // A final beat can only be taken when the output slot is free or draining.
              out_data  <= res;
              out_addr  <= pix_cnt;
              out_valid <= 1'b1;
              tap_cnt   <= '0;
              pix_cnt   <= pix_cnt + 1'b1;
              for (int k = 0; k < 8; k++) acc[k] <= '0;
              if (pix_cnt == PIX_LAST) state <= DRAIN;
            end else begin
              tap_cnt <= tap_cnt + 1'b1;
              for (int k = 0; k < 8; k++) acc[k] <= acc[k] + beat_ext[k];
            end
          end
        end
        DRAIN: begin
          if (out_valid && bus.out_ready) begin
            state      <= DONE;
            layer_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
